// File: rtl/ifu_fetch_queue_pkg.sv
// Shared IFU definitions: instruction/address widths, fetch width and log2ceil.
package ifu_fetch_queue_pkg;

  localparam int unsigned IFU_IW      = 32;
  localparam int unsigned IFU_AW      = 32;
  localparam int unsigned FETCH_WIDTH = 4;

  // Smallest r with 2**r >= v (log2ceil(1) == 0).
  function automatic int unsigned log2ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_aligner.sv
// Line aligner: drops the words of a cache line that precede the fetch PC's
// word offset and packs the remainder, with their PCs, into slots 0..n_enq-1.
module ifu_line_aligner
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned IW = IFU_IW,
  parameter int unsigned AW = IFU_AW
) (
  input  logic [FETCH_WIDTH*IW-1:0]        i_line_data,
  input  logic [AW-1:0]                    i_line_pc,
  output logic [IW-1:0]                    o_instr [FETCH_WIDTH],
  output logic [AW-1:0]                    o_pc    [FETCH_WIDTH],
  output logic [log2ceil(FETCH_WIDTH):0]   o_n_enq
);

  localparam int unsigned BYTE_W = log2ceil(IW / 8);
  localparam int unsigned OFF_W  = log2ceil(FETCH_WIDTH);
  localparam int unsigned LINE_W = BYTE_W + OFF_W;
  localparam int unsigned NW     = OFF_W + 1;

  logic [OFF_W-1:0]  w_off;
  logic [AW-1:0]     w_base;
  logic              w_unused_pc_lsbs;

  assign w_off            = i_line_pc[LINE_W-1:BYTE_W];
  assign w_base           = {i_line_pc[AW-1:LINE_W], {LINE_W{1'b0}}};
  assign w_unused_pc_lsbs = ^i_line_pc[BYTE_W-1:0];
  assign o_n_enq          = NW'(FETCH_WIDTH) - NW'(w_off);

  // Slot k carries line word off+k; slots past the end of the line are zero.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      o_instr[k] = '0;
      o_pc[k]    = '0;
    end
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      int unsigned idx;
      idx = 32'(w_off) + k;
      if (idx < FETCH_WIDTH) begin
        o_instr[k] = i_line_data[IW*idx +: IW];
        o_pc[k]    = w_base + AW'(idx << BYTE_W);
      end
    end
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: circular buffer between icache lines and
// dual-issue decode, with redirect flush.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = IFU_IW,
  parameter int unsigned ADDRESS_WIDTH     = IFU_AW,
  parameter int unsigned DEPTH             = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic                                    line_valid,
  input  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] line_data,
  input  logic [ADDRESS_WIDTH-1:0]                line_pc,
  output logic                                    line_ready,
  output logic                                    inst0_valid,
  output logic [INSTRUCTION_WIDTH-1:0]            inst0,
  output logic [ADDRESS_WIDTH-1:0]                inst0_pc,
  output logic                                    inst1_valid,
  output logic [INSTRUCTION_WIDTH-1:0]            inst1,
  output logic [ADDRESS_WIDTH-1:0]                inst1_pc,
  input  logic [1:0]                              decode_accept,
  output logic [log2ceil(DEPTH):0]                count
);

  localparam int unsigned IW = INSTRUCTION_WIDTH;
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned PW = log2ceil(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = log2ceil(FETCH_WIDTH) + 1;

  logic [IW-1:0] r_instr [DEPTH];
  logic [AW-1:0] r_pc    [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [IW-1:0] w_slot_instr [FETCH_WIDTH];
  logic [AW-1:0] w_slot_pc    [FETCH_WIDTH];
  logic [NW-1:0] w_n_slots;
  logic          w_ready;
  logic          w_enq;
  logic [CW-1:0] w_n_enq;
  logic [1:0]    w_acc;
  logic [CW-1:0] w_n_deq;
  logic [PW-1:0] w_head1;
  logic          w_v0;
  logic          w_v1;

  ifu_line_aligner #(
    .IW (IW),
    .AW (AW)
  ) u_aligner (
    .i_line_data (line_data),
    .i_line_pc   (line_pc),
    .o_instr     (w_slot_instr),
    .o_pc        (w_slot_pc),
    .o_n_enq     (w_n_slots)
  );

  // Ready from registered occupancy only; this cycle's dequeue is not credited.
  assign w_ready = (CW'(DEPTH) - r_count) >= CW'(FETCH_WIDTH);
  assign w_enq   = line_valid && w_ready && !flush;
  assign w_n_enq = w_enq ? CW'(w_n_slots) : '0;
  assign w_acc   = (decode_accept == 2'd3) ? 2'd2 : decode_accept;
  assign w_n_deq = (CW'(w_acc) > r_count) ? r_count : CW'(w_acc);
  assign w_head1 = r_head + PW'(1);

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_deq;
    end
  end

  // Storage write of the aligned slots starting at tail.
  always_ff @(posedge clock) begin
    if (reset && w_enq) begin
      for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
        if (NW'(k) < w_n_slots) begin
          r_instr[r_tail + PW'(k)] <= w_slot_instr[k];
          r_pc[r_tail + PW'(k)]    <= w_slot_pc[k];
        end
      end
    end
  end

  assign w_v0        = reset && (r_count >= CW'(1));
  assign w_v1        = reset && (r_count >= CW'(2));
  assign line_ready  = reset && w_ready;
  assign count       = reset ? r_count : '0;
  assign inst0_valid = w_v0;
  assign inst1_valid = w_v1;
  assign inst0       = w_v0 ? r_instr[r_head]  : '0;
  assign inst0_pc    = w_v0 ? r_pc[r_head]     : '0;
  assign inst1       = w_v1 ? r_instr[w_head1] : '0;
  assign inst1_pc    = w_v1 ? r_pc[w_head1]    : '0;

endmodule
